// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 memory-cycle sequencer.
// Operation and T-state encodings plus the refresh-counter increment helper.
package z80_bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam logic [7:0] R_MASK = 8'h7F;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_NONE  = 2'b11
    } bus_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } tstate_t;

    function automatic logic op_valid(input logic [1:0] op);
        return op != OP_NONE;
    endfunction

    // Only the low seven bits count; bit 7 is preserved across the wrap.
    function automatic logic [7:0] r_incr(input logic [7:0] r);
        return (r & ~R_MASK) | ((r + 8'd1) & R_MASK);
    endfunction

endpackage

// File: rtl/z80_refresh_ctr.sv
// Z80 R register: 7-bit wrapping refresh counter with a parallel load.
// A load always takes priority over an increment requested in the same cycle.
module z80_refresh_ctr
    import z80_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] r
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= 8'h00;
        end else if (load) begin
            r <= load_val;
        end else if (inc) begin
            r <= r_incr(r);
        end
    end

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 memory-cycle sequencer: turns single-cycle core requests into T-state
// accurate bus strobes, captures read data and owns the refresh counter.
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REFRESH_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic [7:0]        i_reg,
    input  logic              r_load,
    input  logic [7:0]        r_load_val,
    output logic [7:0]        r_reg,
    input  logic              WAIT_L,
    output logic              MREQ_L,
    output logic              RD_L,
    output logic              WR_L,
    output logic              M1_L,
    output logic              RFSH_L,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in
);

    tstate_t           state_reg, state_next;
    bus_op_t           op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    bus_op_t           cur_op;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              accept;
    logic              refresh_fetch;
    logic              capture;
    logic              r_inc;

    logic              mreq_next, rd_next, wr_next, m1_next, rfsh_next, rsp_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] dout_next;

    assign refresh_fetch = (op_reg == OP_FETCH) && (REFRESH_EN != 0);

    always_comb begin
        req_ready = 1'b0;
        case (state_reg)
            IDLE:    req_ready = 1'b1;
            T3:      req_ready = !refresh_fetch;
            T4:      req_ready = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Invalid ops complete the handshake but never start a bus cycle.
    assign accept = req_valid && req_ready && op_valid(req_op);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = accept ? T1 : IDLE;
            T1:      state_next = T2;
            T2, TW:  state_next = WAIT_L ? T3 : TW;
            T3:      state_next = refresh_fetch ? T4 : (accept ? T1 : IDLE);
            T4:      state_next = accept ? T1 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cur_op    = accept ? bus_op_t'(req_op) : op_reg;
        cur_addr  = accept ? req_addr : addr_reg;
        cur_wdata = accept ? req_wdata : wdata_reg;
    end

    // Bus pins are computed for the state being entered, then registered.
    always_comb begin
        mreq_next = 1'b1;
        rd_next   = 1'b1;
        wr_next   = 1'b1;
        m1_next   = 1'b1;
        rfsh_next = 1'b1;
        rsp_next  = 1'b0;
        addr_next = addr_bus;
        dout_next = data_out;
        case (state_next)
            T1: begin
                addr_next = cur_addr;
                mreq_next = 1'b0;
                rd_next   = (cur_op == OP_WRITE);
                m1_next   = (cur_op != OP_FETCH);
                if (cur_op == OP_WRITE) begin
                    dout_next = cur_wdata;
                end
            end
            T2, TW: begin
                addr_next = cur_addr;
                mreq_next = 1'b0;
                rd_next   = (cur_op == OP_WRITE);
                wr_next   = (cur_op != OP_WRITE);
                m1_next   = (cur_op != OP_FETCH);
            end
            T3: begin
                rsp_next = 1'b1;
                if (refresh_fetch) begin
                    addr_next = ADDR_W'({i_reg, r_reg});
                    mreq_next = 1'b0;
                    rfsh_next = 1'b0;
                end
            end
            T4: begin
                rfsh_next = 1'b0;
            end
            default: ;
        endcase
    end

    assign capture = ((state_reg == T2) || (state_reg == TW)) && WAIT_L && (op_reg != OP_WRITE);
    assign r_inc   = (state_reg == T4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_FETCH;
            addr_reg  <= '0;
            wdata_reg <= '0;
            MREQ_L    <= 1'b1;
            RD_L      <= 1'b1;
            WR_L      <= 1'b1;
            M1_L      <= 1'b1;
            RFSH_L    <= 1'b1;
            addr_bus  <= '0;
            data_out  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= bus_op_t'(req_op);
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            MREQ_L    <= mreq_next;
            RD_L      <= rd_next;
            WR_L      <= wr_next;
            M1_L      <= m1_next;
            RFSH_L    <= rfsh_next;
            addr_bus  <= addr_next;
            data_out  <= dout_next;
            rsp_valid <= rsp_next;
            if (capture) begin
                rsp_rdata <= data_in;
            end
        end
    end

    z80_refresh_ctr u_refresh (
        .clk      (clk),
        .rst      (rst),
        .inc      (r_inc),
        .load     (r_load),
        .load_val (r_load_val),
        .r        (r_reg)
    );

endmodule
